// File: rtl/axil_wr_arb_mux.sv
// Round-robin arbiter/mux letting N AXI-Lite write masters share one slave port.
// One transaction in flight at a time: IDLE arbitrates on AW, XFER moves AW/W, RESP returns B.
module axil_wr_arb_mux #(
  parameter int N      = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N*ADDR_W-1:0]     s_awaddr,
  input  logic [N-1:0]            s_awvalid,
  output logic [N-1:0]            s_awready,
  input  logic [N*DATA_W-1:0]     s_wdata,
  input  logic [N*DATA_W/8-1:0]   s_wstrb,
  input  logic [N-1:0]            s_wvalid,
  output logic [N-1:0]            s_wready,
  output logic [1:0]              s_bresp,
  output logic [N-1:0]            s_bvalid,
  input  logic [N-1:0]            s_bready,
  output logic [ADDR_W-1:0]       m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W/8-1:0]     m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic                    busy,
  output logic [$clog2(N)-1:0]    grant_id
);

  localparam int ID_W   = $clog2(N);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N - 1);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] pick, cand;
  logic            found;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            aw_hs, w_hs;

  logic [ADDR_W-1:0] awaddr_a [N];
  logic [DATA_W-1:0] wdata_a  [N];
  logic [STRB_W-1:0] wstrb_a  [N];

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign awaddr_a[i] = s_awaddr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i]  = s_wdata[i*DATA_W +: DATA_W];
    assign wstrb_a[i]  = s_wstrb[i*STRB_W +: STRB_W];
  end

  // First AW requester after last_grant, wrapping modulo N.
  always_comb begin
    pick  = last_q;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = ID_W'((32'(last_q) + k) % N);
      if (!found && s_awvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bresp   = 2'b00;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    m_awaddr  = awaddr_a[grant_q];
    m_wdata   = wdata_a[grant_q];
    m_wstrb   = wstrb_a[grant_q];
    case (state_q)
      IDLE: begin
        if (|s_awvalid) begin
          grant_d   = pick;
          last_d    = pick;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = XFER;
        end
      end
      XFER: begin
        m_awvalid          = s_awvalid[grant_q] & ~aw_done_q;
        s_awready[grant_q] = m_awready & ~aw_done_q;
        m_wvalid           = s_wvalid[grant_q] & ~w_done_q;
        s_wready[grant_q]  = m_wready & ~w_done_q;
        aw_hs              = m_awvalid & m_awready;
        w_hs               = m_wvalid & m_wready;
        aw_done_d          = aw_done_q | aw_hs;
        w_done_d           = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = RESP;
      end
      RESP: begin
        s_bvalid[grant_q] = m_bvalid;
        s_bresp           = m_bresp;
        m_bready          = s_bready[grant_q];
        if (m_bvalid && s_bready[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_axil_wr_arb_mux.sv
// Directed bench for axil_wr_arb_mux: a table of full write transactions with
// hand-computed grants, plus sequences for W-before-AW, B backpressure and mid-transfer reset.
module tb_axil_wr_arb_mux;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*AW-1:0] s_awaddr;
  logic [N-1:0]    s_awvalid, s_awready;
  logic [N*DW-1:0] s_wdata;
  logic [N*DW/8-1:0] s_wstrb;
  logic [N-1:0]    s_wvalid, s_wready;
  logic [1:0]      s_bresp;
  logic [N-1:0]    s_bvalid, s_bready;
  logic [AW-1:0]   m_awaddr;
  logic            m_awvalid, m_awready;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_wvalid, m_wready;
  logic [1:0]      m_bresp;
  logic            m_bvalid, m_bready;
  logic            busy;
  logic [1:0]      grant_id;

  axil_wr_arb_mux #(.N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int aw_beats = 0;
  int w_beats = 0;

  logic [31:0] addr_tab [N] = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0040, 32'h0000_0080};
  logic [31:0] data_tab [N] = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF, 32'h4444_0003};
  logic [3:0]  strb_tab [N] = '{4'hF, 4'h3, 4'hC, 4'h1};

  typedef struct {
    logic [3:0]  mask;
    logic [1:0]  bresp;
    int unsigned exp_g;
  } vec_t;
  vec_t vecs [12];

  // Slave-side beat counters, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (m_awvalid && m_awready) aw_beats++;
    if (m_wvalid && m_wready)   w_beats++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [3:0] mask, input logic [1:0] bresp, input int unsigned g);
    logic [3:0] onehot;
    onehot = 4'b0001 << g;
    s_awvalid = mask; s_wvalid = mask; m_awready = 1'b1; m_wready = 1'b1;
    #1;
    check("idle_busy", busy, 0);
    check("idle_m_awvalid", m_awvalid, 0);
    check("idle_s_awready", s_awready, 0);
    tick();
    check("grant_id", grant_id, g);
    check("xfer_busy", busy, 1);
    check("xfer_m_awvalid", m_awvalid, 1);
    check("xfer_m_wvalid", m_wvalid, 1);
    check("m_awaddr", m_awaddr, addr_tab[g]);
    check("m_wdata", m_wdata, data_tab[g]);
    check("m_wstrb", m_wstrb, strb_tab[g]);
    check("s_awready", s_awready, onehot);
    check("s_wready", s_wready, onehot);
    tick();
    s_awvalid[g] = 1'b0; s_wvalid[g] = 1'b0;
    m_bvalid = 1'b1; m_bresp = bresp; s_bready = '1;
    #1;
    check("resp_s_bvalid", s_bvalid, onehot);
    check("resp_s_bresp", s_bresp, bresp);
    check("resp_m_bready", m_bready, 1);
    check("resp_m_awvalid", m_awvalid, 0);
    tick();
    m_bvalid = 1'b0; m_bresp = 2'b00; s_bready = '0;
    #1;
    check("post_busy", busy, 0);
    check("post_s_bresp", s_bresp, 0);
    check("post_s_bvalid", s_bvalid, 0);
  endtask

  initial begin
    int aw0, w0;
    // Rotation from reset, lone requester, 1/3 alternation, then master 0 alone.
    vecs[0]  = '{4'b1111, 2'b00, 0};
    vecs[1]  = '{4'b1111, 2'b01, 1};
    vecs[2]  = '{4'b1111, 2'b10, 2};
    vecs[3]  = '{4'b1111, 2'b11, 3};
    vecs[4]  = '{4'b1111, 2'b00, 0};
    vecs[5]  = '{4'b0100, 2'b00, 2};
    vecs[6]  = '{4'b0100, 2'b01, 2};
    vecs[7]  = '{4'b1010, 2'b00, 3};
    vecs[8]  = '{4'b1010, 2'b10, 1};
    vecs[9]  = '{4'b1010, 2'b00, 3};
    vecs[10] = '{4'b1010, 2'b11, 1};
    vecs[11] = '{4'b0001, 2'b00, 0};

    for (int i = 0; i < N; i++) begin
      s_awaddr[i*AW +: AW]  = addr_tab[i];
      s_wdata[i*DW +: DW]   = data_tab[i];
      s_wstrb[i*4 +: 4]     = strb_tab[i];
    end
    rst_n = 1'b0;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    #12;
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_s_bvalid", s_bvalid, 0);
    check("rst_m_bready", m_bready, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++)
      run_txn(vecs[i].mask, vecs[i].bresp, vecs[i].exp_g);

    // W completes three cycles ahead of AW; exactly one W beat expected.
    aw0 = aw_beats; w0 = w_beats;
    s_awvalid = 4'b0001; s_wvalid = 4'b0001; m_awready = 1'b0; m_wready = 1'b1;
    tick();
    check("wfirst_grant", grant_id, 0);
    check("wfirst_m_wvalid", m_wvalid, 1);
    check("wfirst_m_awvalid", m_awvalid, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wfirst_wvalid_drop", m_wvalid, 0);
      check("wfirst_s_wready", s_wready, 0);
      check("wfirst_still_xfer", m_awvalid, 1);
      check("wfirst_no_bvalid", s_bvalid, 0);
    end
    m_awready = 1'b1;
    tick();
    s_awvalid = '0; s_wvalid = '0;
    m_bvalid = 1'b1; m_bresp = 2'b00; s_bready = 4'b0001;
    #1;
    check("wfirst_resp_bvalid", s_bvalid, 4'b0001);
    check("wfirst_resp_awvalid", m_awvalid, 0);
    check("wfirst_w_beats", w_beats - w0, 1);
    check("wfirst_aw_beats", aw_beats - aw0, 1);
    tick();
    m_bvalid = 1'b0; s_bready = '0;
    #1;
    check("wfirst_idle", busy, 0);

    // SLVERR held against B backpressure for four cycles.
    s_awvalid = 4'b0010; s_wvalid = 4'b0010; m_awready = 1'b1; m_wready = 1'b1;
    tick();
    check("bhold_grant", grant_id, 1);
    tick();
    s_awvalid = '0; s_wvalid = '0;
    m_bvalid = 1'b1; m_bresp = 2'b10; s_bready = '0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) s_bready = 4'b0010;
      #1;
      check("bhold_s_bvalid", s_bvalid, 4'b0010);
      check("bhold_s_bresp", s_bresp, 2'b10);
      check("bhold_busy", busy, 1);
      check("bhold_m_bready", m_bready, (k == 4) ? 1 : 0);
      tick();
    end
    m_bvalid = 1'b0; m_bresp = 2'b00; s_bready = '0;
    #1;
    check("bhold_idle", busy, 0);
    check("bhold_bresp_idle", s_bresp, 0);

    // Reset while AW done and W pending: everything drops, priority restarts at 0.
    s_awvalid = 4'b0100; s_wvalid = 4'b0100; m_awready = 1'b1; m_wready = 1'b0;
    tick();
    check("rstx_grant", grant_id, 2);
    tick();
    check("rstx_aw_done_gate", m_awvalid, 0);
    check("rstx_m_wvalid", m_wvalid, 1);
    rst_n = 1'b0;
    #1;
    check("rstx_busy", busy, 0);
    check("rstx_grant_id", grant_id, 0);
    check("rstx_m_wvalid_low", m_wvalid, 0);
    check("rstx_s_wready", s_wready, 0);
    check("rstx_s_awready", s_awready, 0);
    check("rstx_s_bvalid", s_bvalid, 0);
    s_awvalid = '0; s_wvalid = '0; m_wready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rstx_no_bvalid", s_bvalid, 0);
    run_txn(4'b1001, 2'b01, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
